// File: rtl/dcache_assoc_controller.sv
// dcache_assoc_controller
//   N-way set-associative, write-allocate, write-back data cache controller
//   with true-LRU replacement and a flush walk that writes back dirty lines.
//   Hits complete in the COMPARE cycle (cpu_ready/cpu_rdata are combinational
//   from registered state and storage). Memory-side outputs are registered.
//   Optional macro DCACHE_STATS_EN adds stat_hits / stat_misses counters.
module dcache_assoc_controller #(
   parameter int ADDR_W      = 32,
   parameter int WAYS        = 2,
   parameter int SETS        = 16,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         cpu_addr,
   input  logic [31:0]               cpu_wdata,
   input  logic [3:0]                cpu_byte_en,
   input  logic                      cpu_rw,
   input  logic                      cpu_valid,
   output logic [31:0]               cpu_rdata,
   output logic                      cpu_ready,
   input  logic                      flush_req,
   output logic                      flush_done,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [32*BLOCK_WORDS-1:0] mem_wdata,
   output logic                      mem_rw,
   output logic                      mem_valid,
   input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
   input  logic                      mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]               stat_hits,
   output logic [31:0]               stat_misses
`endif
);

   localparam int OFF    = 2 + $clog2(BLOCK_WORDS);
   localparam int IDX    = $clog2(SETS);
   localparam int TAG    = ADDR_W - OFF - IDX;
   localparam int WAY_W  = $clog2(WAYS);
   localparam int LINE_W = 32 * BLOCK_WORDS;
   localparam int WSEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

   typedef enum logic [2:0] {
      S_COMPARE    = 3'd0,
      S_WRITE_BACK = 3'd1,
      S_ALLOCATE   = 3'd2,
      S_FLUSH      = 3'd3,
      S_FLUSH_WB   = 3'd4
   } state_t;

   // Line storage: combinational read, synchronous write
   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [TAG-1:0]    r_tag   [SETS][WAYS];
   logic [LINE_W-1:0] r_data  [SETS][WAYS];
   logic [WAY_W-1:0]  r_age   [SETS][WAYS];

   state_t            r_state;
   logic              r_mem_valid;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [LINE_W-1:0] r_mem_wdata;
   logic              r_flush_done;
   logic [TAG-1:0]    r_miss_tag;
   logic [IDX-1:0]    r_miss_idx;
   logic [WAY_W-1:0]  r_victim;
   logic [IDX-1:0]    r_fl_set;
   logic [WAY_W-1:0]  r_fl_way;
`ifdef DCACHE_STATS_EN
   logic [31:0]       r_stat_hits;
   logic [31:0]       r_stat_misses;
   logic              r_retry;
`endif

   logic [IDX-1:0]    w_idx;
   logic [TAG-1:0]    w_tag;
   logic [WSEL_W-1:0] w_word;
   logic              w_hit;
   logic [WAY_W-1:0]  w_hit_way;
   logic              w_found_inv;
   logic [WAY_W-1:0]  w_victim;
   logic [LINE_W-1:0] w_line;
   logic [LINE_W-1:0] w_merged;
   logic [31:0]       w_rword;
   logic              w_cpu_hit;
   logic              w_fl_last;

   assign w_idx  = cpu_addr[OFF+IDX-1:OFF];
   assign w_tag  = cpu_addr[ADDR_W-1:OFF+IDX];
   assign w_word = (BLOCK_WORDS > 1) ? WSEL_W'(cpu_addr >> 2) : {WSEL_W{1'b0}};

   // Tag compare across the indexed set and victim choice for a miss
   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = {WAY_W{1'b0}};
      w_found_inv = 1'b0;
      w_victim    = {WAY_W{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
         if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end else begin
            w_hit     = w_hit;
         end
      end
      // Lowest-index invalid way takes priority over the LRU way
      for (int w = 0; w < WAYS; w++) begin
         if (!w_found_inv && !r_valid[w_idx][w]) begin
            w_found_inv = 1'b1;
            w_victim    = WAY_W'(w);
         end else begin
            w_found_inv = w_found_inv;
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!w_found_inv && (r_age[w_idx][w] == WAY_W'(WAYS - 1))) begin
            w_victim = WAY_W'(w);
         end else begin
            w_victim = w_victim;
         end
      end
   end

   // Word read and byte-enable merge of the hit line
   always_comb begin
      w_line   = r_data[w_idx][w_hit_way];
      w_rword  = w_line[w_word*32 +: 32];
      w_merged = w_line;
      for (int b = 0; b < 4; b++) begin
         if (cpu_byte_en[b]) begin
            w_merged[w_word*32 + b*8 +: 8] = cpu_wdata[b*8 +: 8];
         end else begin
            w_merged[w_word*32 + b*8 +: 8] = w_line[w_word*32 + b*8 +: 8];
         end
      end
   end

   assign w_cpu_hit = !reset && (r_state == S_COMPARE) && cpu_valid && w_hit;
   assign w_fl_last = (r_fl_set == IDX'(SETS - 1)) && (r_fl_way == WAY_W'(WAYS - 1));

   assign cpu_ready  = w_cpu_hit;
   assign cpu_rdata  = (w_cpu_hit && !cpu_rw) ? w_rword : 32'h0000_0000;
   assign mem_valid  = r_mem_valid;
   assign mem_rw     = r_mem_rw;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign flush_done = r_flush_done;
`ifdef DCACHE_STATS_EN
   assign stat_hits   = r_stat_hits;
   assign stat_misses = r_stat_misses;
`endif

   // Controller FSM, storage updates, LRU ages and memory-side outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_COMPARE;
         r_mem_valid  <= 1'b0;
         r_mem_rw     <= 1'b0;
         r_mem_addr   <= {ADDR_W{1'b0}};
         r_mem_wdata  <= {LINE_W{1'b0}};
         r_flush_done <= 1'b0;
         r_miss_tag   <= {TAG{1'b0}};
         r_miss_idx   <= {IDX{1'b0}};
         r_victim     <= {WAY_W{1'b0}};
         r_fl_set     <= {IDX{1'b0}};
         r_fl_way     <= {WAY_W{1'b0}};
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= {WAYS{1'b0}};
            r_dirty[s] <= {WAYS{1'b0}};
            for (int w = 0; w < WAYS; w++) begin
               r_age[s][w] <= WAY_W'(w);
            end
         end
`ifdef DCACHE_STATS_EN
         r_stat_hits   <= 32'd0;
         r_stat_misses <= 32'd0;
         r_retry       <= 1'b0;
`endif
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            S_COMPARE: begin
`ifdef DCACHE_STATS_EN
               r_retry <= 1'b0;
`endif
               if (cpu_valid && w_hit) begin
                  if (cpu_rw) begin
                     r_data[w_idx][w_hit_way]  <= w_merged;
                     r_dirty[w_idx][w_hit_way] <= 1'b1;
                  end
                  for (int w = 0; w < WAYS; w++) begin
                     if (r_age[w_idx][w] < r_age[w_idx][w_hit_way]) begin
                        r_age[w_idx][w] <= r_age[w_idx][w] + WAY_W'(1);
                     end
                  end
                  r_age[w_idx][w_hit_way] <= {WAY_W{1'b0}};
`ifdef DCACHE_STATS_EN
                  if (!r_retry) begin
                     r_stat_hits <= r_stat_hits + 32'd1;
                  end
`endif
               end else if (cpu_valid) begin
                  // Miss: remember the request so the fill survives cpu_valid dropping
                  r_miss_tag  <= w_tag;
                  r_miss_idx  <= w_idx;
                  r_victim    <= w_victim;
                  r_mem_valid <= 1'b1;
`ifdef DCACHE_STATS_EN
                  r_stat_misses <= r_stat_misses + 32'd1;
`endif
                  if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                     r_mem_rw    <= 1'b1;
                     r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx, {OFF{1'b0}}};
                     r_mem_wdata <= r_data[w_idx][w_victim];
                     r_state     <= S_WRITE_BACK;
                  end else begin
                     r_mem_rw    <= 1'b0;
                     r_mem_addr  <= {w_tag, w_idx, {OFF{1'b0}}};
                     r_state     <= S_ALLOCATE;
                  end
               end else if (flush_req) begin
                  r_fl_set <= {IDX{1'b0}};
                  r_fl_way <= {WAY_W{1'b0}};
                  r_state  <= S_FLUSH;
               end
            end
            S_WRITE_BACK: begin
               if (mem_ready) begin
                  r_mem_rw   <= 1'b0;
                  r_mem_addr <= {r_miss_tag, r_miss_idx, {OFF{1'b0}}};
                  r_state    <= S_ALLOCATE;
               end
            end
            S_ALLOCATE: begin
               if (mem_ready) begin
                  r_data[r_miss_idx][r_victim]  <= mem_rdata;
                  r_tag[r_miss_idx][r_victim]   <= r_miss_tag;
                  r_valid[r_miss_idx][r_victim] <= 1'b1;
                  r_dirty[r_miss_idx][r_victim] <= 1'b0;
                  r_mem_valid <= 1'b0;
                  r_state     <= S_COMPARE;
`ifdef DCACHE_STATS_EN
                  r_retry     <= 1'b1;
`endif
               end
            end
            S_FLUSH, S_FLUSH_WB: begin
               if ((r_state == S_FLUSH) && r_valid[r_fl_set][r_fl_way] && r_dirty[r_fl_set][r_fl_way]) begin
                  r_mem_valid <= 1'b1;
                  r_mem_rw    <= 1'b1;
                  r_mem_addr  <= {r_tag[r_fl_set][r_fl_way], r_fl_set, {OFF{1'b0}}};
                  r_mem_wdata <= r_data[r_fl_set][r_fl_way];
                  r_state     <= S_FLUSH_WB;
               end else if ((r_state == S_FLUSH) || mem_ready) begin
                  // Current line is clean or its write-back just completed
                  if (r_state == S_FLUSH_WB) begin
                     r_dirty[r_fl_set][r_fl_way] <= 1'b0;
                     r_mem_valid <= 1'b0;
                     r_mem_rw    <= 1'b0;
                  end
                  if (w_fl_last) begin
                     r_flush_done <= 1'b1;
                     r_state      <= S_COMPARE;
                  end else begin
                     r_state <= S_FLUSH;
                     if (r_fl_way == WAY_W'(WAYS - 1)) begin
                        r_fl_way <= {WAY_W{1'b0}};
                        r_fl_set <= r_fl_set + IDX'(1);
                     end else begin
                        r_fl_way <= r_fl_way + WAY_W'(1);
                     end
                  end
               end
            end
            default: begin
               r_mem_valid <= 1'b0;
               r_state     <= S_COMPARE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_assoc_controller.sv
// Directed bench for dcache_assoc_controller (WAYS=2, SETS=16, BLOCK_WORDS=4).
// A small memory responder answers requests after two cycles and logs every
// transaction so the scenarios can check write-back/fill order and contents.
module tb_dcache_assoc_controller;

   logic         clock = 1'b0;
   logic         reset;
   logic [31:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic [3:0]   cpu_byte_en;
   logic         cpu_rw;
   logic         cpu_valid;
   logic [31:0]  cpu_rdata;
   logic         cpu_ready;
   logic         flush_req;
   logic         flush_done;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_rw;
   logic         mem_valid;
   logic [127:0] mem_rdata;
   logic         mem_ready;
`ifdef DCACHE_STATS_EN
   logic [31:0]  stat_hits;
   logic [31:0]  stat_misses;
`endif

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int fd_count = 0;
   bit mem_hold = 1'b0;

   typedef struct {
      bit          rw;
      logic [31:0] addr;
      logic [31:0] w0;
   } mem_txn_t;
   mem_txn_t     log_q[$];
   logic [127:0] mem_model [logic [31:0]];

   dcache_assoc_controller #(
      .ADDR_W(32), .WAYS(2), .SETS(16), .BLOCK_WORDS(4)
   ) dut (
      .clock(clock), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
      .cpu_rw(cpu_rw), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .flush_req(flush_req), .flush_done(flush_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_valid(mem_valid),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [127:0] model_line(input logic [31:0] a);
      logic [127:0] l;
      if (mem_model.exists(a)) begin
         l = mem_model[a];
      end else begin
         for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hC0DE_0000 | ((a + 32'(4*k)) & 32'h0000_FFFF);
      end
      return l;
   endfunction

   // Memory responder: two-cycle latency, one-cycle mem_ready, logs traffic
   initial begin
      int lat;
      lat = 0;
      mem_ready = 1'b0;
      mem_rdata = 128'd0;
      forever begin
         @(negedge clock);
         if (flush_done === 1'b1) fd_count++;
         if (mem_ready) begin
            mem_ready = 1'b0;
            lat = 0;
         end else if (mem_valid === 1'b1 && !reset && !mem_hold) begin
            lat++;
            if (lat >= 2) begin
               if (mem_rw) begin
                  mem_model[mem_addr] = mem_wdata;
                  log_q.push_back('{1'b1, mem_addr, mem_wdata[31:0]});
               end else begin
                  mem_rdata = model_line(mem_addr);
                  log_q.push_back('{1'b0, mem_addr, mem_rdata[31:0]});
               end
               mem_ready = 1'b1;
            end
         end else begin
            lat = 0;
         end
      end
   end

   // Global time bound so the run always ends
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miss_cnt);
      $fatal(1, "time limit");
   end

   task automatic cpu_op(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output int lat);
      rd  = 32'd0;
      lat = -1;
      @(negedge clock);
      cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd; cpu_byte_en = be; cpu_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (cpu_ready === 1'b1) begin
            rd  = cpu_rdata;
            lat = i;
            break;
         end
         @(negedge clock);
      end
      @(negedge clock);
      cpu_valid = 1'b0;
      vec_cnt++;
      if (lat < 0) begin
         miss_cnt++;
         $display("FAIL cpu_timeout addr=%h: got no cpu_ready, expected cpu_ready within 100 cycles", addr);
      end
   endtask

   task automatic do_flush();
      int start;
      bit done;
      start = fd_count;
      done  = 1'b0;
      @(negedge clock); flush_req = 1'b1;
      @(negedge clock); flush_req = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock); #2;
         if (fd_count != start) begin done = 1'b1; break; end
      end
      vec_cnt++;
      if (!done) begin
         miss_cnt++;
         $display("FAIL flush_timeout: got no flush_done, expected flush_done within 500 cycles");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      cpu_byte_en = 4'h0; flush_req = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      vec_cnt++; if (mem_valid !== 1'b0)  begin miss_cnt++; $display("FAIL rst_mem_valid: got %b expected 0", mem_valid); end
      vec_cnt++; if (mem_rw !== 1'b0)     begin miss_cnt++; $display("FAIL rst_mem_rw: got %b expected 0", mem_rw); end
      vec_cnt++; if (mem_addr !== 32'd0)  begin miss_cnt++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
      vec_cnt++; if (cpu_ready !== 1'b0)  begin miss_cnt++; $display("FAIL rst_cpu_ready: got %b expected 0", cpu_ready); end
      vec_cnt++; if (flush_done !== 1'b0) begin miss_cnt++; $display("FAIL rst_flush_done: got %b expected 0", flush_done); end
      vec_cnt++; if (cpu_rdata !== 32'd0) begin miss_cnt++; $display("FAIL rst_cpu_rdata: got %h expected 0", cpu_rdata); end
      reset = 1'b0;
   endtask

   task automatic test_cold_write();
      logic [31:0] rd; int lat;
      log_q.delete();
      cpu_op(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, rd, lat);
      vec_cnt++; if (lat <= 0) begin miss_cnt++; $display("FAIL cold_miss_latency: got %0d expected >0", lat); end
      vec_cnt++; if (log_q.size() != 1) begin miss_cnt++; $display("FAIL cold_txn_count: got %0d expected 1", log_q.size()); end
      else begin
         vec_cnt++; if (log_q[0].rw !== 1'b0 || log_q[0].addr !== 32'h40) begin
            miss_cnt++; $display("FAIL cold_fill: got rw=%b addr=%h expected rw=0 addr=00000040", log_q[0].rw, log_q[0].addr);
         end
      end
      cpu_op(1'b0, 32'h40, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (rd !== 32'hDEAD_BEEF) begin miss_cnt++; $display("FAIL cold_readback: got %h expected deadbeef", rd); end
      vec_cnt++; if (lat != 0) begin miss_cnt++; $display("FAIL cold_hit_latency: got %0d expected 0", lat); end
      vec_cnt++; if (log_q.size() != 1) begin miss_cnt++; $display("FAIL cold_hit_no_mem: got %0d txns expected 1", log_q.size()); end
   endtask

   task automatic test_byte_merge();
      logic [31:0] rd; int lat;
      cpu_op(1'b1, 32'h44, 32'h0000_00AA, 4'b0001, rd, lat);
      vec_cnt++; if (lat != 0) begin miss_cnt++; $display("FAIL merge_write_hit: got latency %0d expected 0", lat); end
      cpu_op(1'b0, 32'h44, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (rd !== 32'h1122_33AA) begin miss_cnt++; $display("FAIL merge_read: got %h expected 112233aa", rd); end
      cpu_op(1'b0, 32'h48, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (rd !== 32'h99AA_BBCC) begin miss_cnt++; $display("FAIL merge_word2: got %h expected 99aabbcc", rd); end
   endtask

   task automatic test_lru();
      logic [31:0] rd; int lat;
      log_q.delete();
      cpu_op(1'b0, 32'h140, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (rd !== 32'hC0DE_0140) begin miss_cnt++; $display("FAIL lru_fill140: got %h expected c0de0140", rd); end
      cpu_op(1'b0, 32'h40, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (lat != 0) begin miss_cnt++; $display("FAIL lru_hit40: got latency %0d expected 0", lat); end
      cpu_op(1'b0, 32'h240, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (rd !== 32'hC0DE_0240) begin miss_cnt++; $display("FAIL lru_fill240: got %h expected c0de0240", rd); end
      vec_cnt++; if (log_q.size() != 2 || log_q[1].rw !== 1'b0 || log_q[1].addr !== 32'h240) begin
         miss_cnt++; $display("FAIL lru_clean_evict: got %0d txns expected 2 fills only", log_q.size());
      end
      log_q.delete();
      cpu_op(1'b0, 32'h140, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (log_q.size() != 2) begin miss_cnt++; $display("FAIL lru_wb_count: got %0d expected 2", log_q.size()); end
      else begin
         vec_cnt++; if (log_q[0].rw !== 1'b1 || log_q[0].addr !== 32'h40 || log_q[0].w0 !== 32'hDEAD_BEEF) begin
            miss_cnt++; $display("FAIL lru_wb: got rw=%b addr=%h w0=%h expected rw=1 addr=00000040 w0=deadbeef",
                                 log_q[0].rw, log_q[0].addr, log_q[0].w0);
         end
         vec_cnt++; if (log_q[1].rw !== 1'b0 || log_q[1].addr !== 32'h140) begin
            miss_cnt++; $display("FAIL lru_refill: got rw=%b addr=%h expected rw=0 addr=00000140", log_q[1].rw, log_q[1].addr);
         end
      end
      vec_cnt++; if (rd !== 32'hC0DE_0140) begin miss_cnt++; $display("FAIL lru_read140: got %h expected c0de0140", rd); end
`ifdef DCACHE_STATS_EN
      vec_cnt++; if (stat_hits !== 32'd5)   begin miss_cnt++; $display("FAIL stat_hits: got %0d expected 5", stat_hits); end
      vec_cnt++; if (stat_misses !== 32'd4) begin miss_cnt++; $display("FAIL stat_misses: got %0d expected 4", stat_misses); end
`endif
   endtask

   task automatic test_flush();
      logic [31:0] rd; int lat; int fd0;
      cpu_op(1'b1, 32'h990, 32'h1234_5678, 4'hF, rd, lat);
      cpu_op(1'b1, 32'h244, 32'hCAFE_F00D, 4'hF, rd, lat);
      log_q.delete();
      fd0 = fd_count;
      do_flush();
      repeat (3) @(negedge clock);
      vec_cnt++; if (log_q.size() != 2) begin miss_cnt++; $display("FAIL flush_wb_count: got %0d expected 2", log_q.size()); end
      else begin
         vec_cnt++; if (log_q[0].rw !== 1'b1 || log_q[0].addr !== 32'h240 || log_q[0].w0 !== 32'hC0DE_0240) begin
            miss_cnt++; $display("FAIL flush_wb_set4: got rw=%b addr=%h w0=%h expected rw=1 addr=00000240 w0=c0de0240",
                                 log_q[0].rw, log_q[0].addr, log_q[0].w0);
         end
         vec_cnt++; if (log_q[1].rw !== 1'b1 || log_q[1].addr !== 32'h990 || log_q[1].w0 !== 32'h1234_5678) begin
            miss_cnt++; $display("FAIL flush_wb_set9: got rw=%b addr=%h w0=%h expected rw=1 addr=00000990 w0=12345678",
                                 log_q[1].rw, log_q[1].addr, log_q[1].w0);
         end
      end
      vec_cnt++; if (fd_count != fd0 + 1) begin miss_cnt++; $display("FAIL flush_done_once: got %0d pulses expected 1", fd_count - fd0); end
      log_q.delete();
      do_flush();
      repeat (3) @(negedge clock);
      vec_cnt++; if (log_q.size() != 0) begin miss_cnt++; $display("FAIL reflush_wb_count: got %0d expected 0", log_q.size()); end
      vec_cnt++; if (fd_count != fd0 + 2) begin miss_cnt++; $display("FAIL reflush_done: got %0d pulses expected 2", fd_count - fd0); end
      cpu_op(1'b0, 32'h244, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (rd !== 32'hCAFE_F00D || lat != 0) begin
         miss_cnt++; $display("FAIL flush_keeps_valid: got %h lat=%0d expected cafef00d lat=0", rd, lat);
      end
   endtask

   task automatic test_reset_midwb();
      logic [31:0] rd; int lat; bit seen;
      cpu_op(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, rd, lat);
      cpu_op(1'b0, 32'h120, 32'd0, 4'h0, rd, lat);
      log_q.delete();
      mem_hold = 1'b1;
      @(negedge clock);
      cpu_rw = 1'b0; cpu_addr = 32'h220; cpu_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (mem_valid === 1'b1 && mem_rw === 1'b1) begin seen = 1'b1; break; end
      end
      vec_cnt++; if (!seen) begin miss_cnt++; $display("FAIL midwb_start: got no write-back request expected one"); end
      vec_cnt++; if (mem_addr !== 32'h20) begin miss_cnt++; $display("FAIL midwb_addr: got %h expected 00000020", mem_addr); end
      reset = 1'b1; cpu_valid = 1'b0;
      @(negedge clock); #1;
      vec_cnt++; if (mem_valid !== 1'b0) begin miss_cnt++; $display("FAIL midwb_drop: got mem_valid=%b expected 0", mem_valid); end
      reset = 1'b0;
      mem_hold = 1'b0;
      vec_cnt++; if (log_q.size() != 0) begin miss_cnt++; $display("FAIL midwb_no_write: got %0d txns expected 0", log_q.size()); end
      cpu_op(1'b0, 32'h40, 32'd0, 4'h0, rd, lat);
      vec_cnt++; if (lat <= 0) begin miss_cnt++; $display("FAIL post_reset_miss: got latency %0d expected >0", lat); end
      vec_cnt++; if (log_q.size() < 1 || log_q[0].rw !== 1'b0 || log_q[0].addr !== 32'h40) begin
         miss_cnt++; $display("FAIL post_reset_fill: got %0d txns expected first a fill of 00000040", log_q.size());
      end
      vec_cnt++; if (rd !== 32'hDEAD_BEEF) begin miss_cnt++; $display("FAIL post_reset_data: got %h expected deadbeef", rd); end
   endtask

   initial begin
      mem_model[32'h40] = {32'h0102_0304, 32'h99AA_BBCC, 32'h1122_3344, 32'h5566_7788};
      test_reset();
      test_cold_write();
      test_byte_merge();
      test_lru();
      test_flush();
      test_reset_midwb();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
